// File: rtl/clock_pkg.sv
// Shared types and BCD limits for the HH:MM time-set path.
// Holds only declarations: no logic, latency or flow control.
package clock_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_RUN         = 2'd0,
        ST_SET_HOURS   = 2'd1,
        ST_SET_MINUTES = 2'd2,
        ST_COMMIT      = 2'd3
    } set_state_t;

    localparam int HOURS_MAX_TENS       = 2;
    localparam int HOURS_MAX_UNITS_AT_2 = 3;
    localparam int MINUTES_MAX_TENS     = 5;
    localparam int BCD_MAX              = 9;

    // Only the pair being edited blinks; the phase is 0 (visible) outside set mode anyway.
    function automatic logic [3:0] blank_mask(input set_state_t st, input logic phase);
        case (st)
            ST_SET_HOURS:   return {phase, phase, 2'b00};
            ST_SET_MINUTES: return {2'b00, phase, phase};
            default:        return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Button, live-time and edited-time bundle between the buttons/timekeeper and time_set_ctrl.
// Plain wires: no latency; no backpressure, Load is a single-cycle strobe.
interface time_set_ctrl_if;
    import clock_pkg::*;

    logic BtnMode;
    logic BtnInc;
    bcd_t CurHoursTens;
    bcd_t CurHoursUnits;
    bcd_t CurMinutesTens;
    bcd_t CurMinutesUnits;
    bcd_t SetHoursTens;
    bcd_t SetHoursUnits;
    bcd_t SetMinutesTens;
    bcd_t SetMinutesUnits;
    logic Load;
    logic Run;
    logic [3:0] DigitBlank;

    modport slave (
        input  BtnMode, BtnInc,
        input  CurHoursTens, CurHoursUnits, CurMinutesTens, CurMinutesUnits,
        output SetHoursTens, SetHoursUnits, SetMinutesTens, SetMinutesUnits,
        output Load, Run, DigitBlank
    );

    modport master (
        output BtnMode, BtnInc,
        output CurHoursTens, CurHoursUnits, CurMinutesTens, CurMinutesUnits,
        input  SetHoursTens, SetHoursUnits, SetMinutesTens, SetMinutesUnits,
        input  Load, Run, DigitBlank
    );

endinterface

// File: rtl/bcd_pair_inc.sv
// Combinational +1 on a BCD tens/units pair, wrapping WRAP -> 00 (23 for hours, 59 for minutes).
// Zero latency, no flow control.
module bcd_pair_inc
    import clock_pkg::*;
#(
    parameter int WRAP = 59
) (
    input  bcd_t i_tens,
    input  bcd_t i_units,
    output bcd_t o_tens,
    output bcd_t o_units
);

    localparam bcd_t WRAP_TENS  = bcd_t'(WRAP / 10);
    localparam bcd_t WRAP_UNITS = bcd_t'(WRAP % 10);
    localparam bcd_t UNITS_TOP  = bcd_t'(BCD_MAX);

    always_comb begin
        o_tens  = i_tens;
        o_units = i_units + bcd_t'(1);
        if ((i_tens == WRAP_TENS) && (i_units == WRAP_UNITS)) begin
            o_tens  = '0;
            o_units = '0;
        end else if (i_units >= UNITS_TOP) begin
            o_tens  = i_tens + bcd_t'(1);
            o_units = '0;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven HH:MM set sequencer: freeze, edit hours then minutes with blinking pair, commit via Load.
// Responds on the edge after a button rises; no backpressure. TIME_SET_AUTO_REPEAT_EN adds held-Inc auto-repeat.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_HZ    = 100000000,
    parameter int BLINK_HZ  = 2,
    parameter int TIMEOUT_S = 10,
    parameter int HOLD_MS   = 500,
    parameter int REPEAT_HZ = 8
) (
    input  logic           Clk_100M,
    input  logic           Reset,
    time_set_ctrl_if.slave bus
);

    localparam int BLINK_HALF   = CLK_HZ / (2 * BLINK_HZ);
    localparam int BLINK_W      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int TO_CYC       = TIMEOUT_S * CLK_HZ;
    localparam int TO_W         = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam int HOURS_WRAP   = HOURS_MAX_TENS * 10 + HOURS_MAX_UNITS_AT_2;
    localparam int MINUTES_WRAP = MINUTES_MAX_TENS * 10 + BCD_MAX;

    set_state_t         r_state;
    set_state_t         w_state_nxt;
    logic               r_mode_q;
    logic               r_inc_q;
    logic               r_armed;
    bcd_t               r_set_ht;
    bcd_t               r_set_hu;
    bcd_t               r_set_mt;
    bcd_t               r_set_mu;
    bcd_t               w_set_ht_nxt;
    bcd_t               w_set_hu_nxt;
    bcd_t               w_set_mt_nxt;
    bcd_t               w_set_mu_nxt;
    bcd_t               w_hrs_inc_t;
    bcd_t               w_hrs_inc_u;
    bcd_t               w_min_inc_t;
    bcd_t               w_min_inc_u;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_phase;
    logic [TO_W-1:0]    r_to_cnt;
    logic               w_mode_ev;
    logic               w_inc_edge;
    logic               w_rep_ev;
    logic               w_inc_ev;
    logic               w_in_set;
    logic               w_timeout;
    logic               w_entry;
    logic               w_run;
    logic               w_load;
    logic [3:0]         w_blank;

    // r_armed masks the first cycle after reset so a button already held at reset exit is not an event.
    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            r_mode_q <= 1'b0;
            r_inc_q  <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_mode_q <= bus.BtnMode;
            r_inc_q  <= bus.BtnInc;
            r_armed  <= 1'b1;
        end
    end

    assign w_mode_ev  = r_armed & bus.BtnMode & ~r_mode_q;
    assign w_inc_edge = r_armed & bus.BtnInc & ~r_inc_q;
    assign w_inc_ev   = w_inc_edge | w_rep_ev;
    assign w_in_set   = (r_state == ST_SET_HOURS) || (r_state == ST_SET_MINUTES);
    assign w_timeout  = w_in_set && (r_to_cnt == TO_W'(TO_CYC - 1));

`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam int HOLD_CYC = (CLK_HZ / 1000) * HOLD_MS;
    localparam int REP_CYC  = CLK_HZ / REPEAT_HZ;
    localparam int REP_MAX  = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
    localparam int REP_W    = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_act;
    logic             r_rep_held;
    logic [REP_W-1:0] w_rep_lim;

    // First repeat waits the hold time, subsequent ones the repeat period.
    assign w_rep_lim = r_rep_held ? REP_W'(REP_CYC - 1) : REP_W'(HOLD_CYC - 1);
    assign w_rep_ev  = r_rep_act & bus.BtnInc & w_in_set & (r_rep_cnt == w_rep_lim);

    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            r_rep_cnt  <= '0;
            r_rep_act  <= 1'b0;
            r_rep_held <= 1'b0;
        end else if (w_inc_edge && w_in_set) begin
            r_rep_cnt  <= '0;
            r_rep_act  <= 1'b1;
            r_rep_held <= 1'b0;
        end else if (!bus.BtnInc || !w_in_set) begin
            r_rep_cnt  <= '0;
            r_rep_act  <= 1'b0;
            r_rep_held <= 1'b0;
        end else if (r_rep_act) begin
            if (w_rep_ev) begin
                r_rep_cnt  <= '0;
                r_rep_held <= 1'b1;
            end else begin
                r_rep_cnt <= r_rep_cnt + REP_W'(1);
            end
        end
    end
`else
    logic w_rep_unused;

    assign w_rep_ev     = 1'b0;
    assign w_rep_unused = ^{HOLD_MS, REPEAT_HZ};
`endif

    bcd_pair_inc #(.WRAP(HOURS_WRAP)) u_hours_inc (
        .i_tens  (r_set_ht),
        .i_units (r_set_hu),
        .o_tens  (w_hrs_inc_t),
        .o_units (w_hrs_inc_u)
    );

    bcd_pair_inc #(.WRAP(MINUTES_WRAP)) u_minutes_inc (
        .i_tens  (r_set_mt),
        .i_units (r_set_mu),
        .o_tens  (w_min_inc_t),
        .o_units (w_min_inc_u)
    );

    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            r_state  <= ST_RUN;
            r_set_ht <= '0;
            r_set_hu <= '0;
            r_set_mt <= '0;
            r_set_mu <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_set_ht <= w_set_ht_nxt;
            r_set_hu <= w_set_hu_nxt;
            r_set_mt <= w_set_mt_nxt;
            r_set_mu <= w_set_mu_nxt;
        end
    end

    // Mode outranks Inc, and any event outranks a timeout landing on the same cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_set_ht_nxt = r_set_ht;
        w_set_hu_nxt = r_set_hu;
        w_set_mt_nxt = r_set_mt;
        w_set_mu_nxt = r_set_mu;
        w_run        = 1'b0;
        w_load       = 1'b0;
        w_blank      = blank_mask(r_state, r_phase);
        case (r_state)
            ST_RUN: begin
                w_run = 1'b1;
                if (w_mode_ev) begin
                    w_state_nxt  = ST_SET_HOURS;
                    w_set_ht_nxt = bus.CurHoursTens;
                    w_set_hu_nxt = bus.CurHoursUnits;
                    w_set_mt_nxt = bus.CurMinutesTens;
                    w_set_mu_nxt = bus.CurMinutesUnits;
                end
            end
            ST_SET_HOURS: begin
                if (w_mode_ev) begin
                    w_state_nxt = ST_SET_MINUTES;
                end else if (w_inc_ev) begin
                    w_set_ht_nxt = w_hrs_inc_t;
                    w_set_hu_nxt = w_hrs_inc_u;
                end else if (w_timeout) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_SET_MINUTES: begin
                if (w_mode_ev) begin
                    w_state_nxt = ST_COMMIT;
                end else if (w_inc_ev) begin
                    w_set_mt_nxt = w_min_inc_t;
                    w_set_mu_nxt = w_min_inc_u;
                end else if (w_timeout) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_COMMIT: begin
                w_load      = 1'b1;
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign w_entry = (w_state_nxt != r_state);

    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (!w_in_set || w_entry || w_inc_ev) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
        end
    end

    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            r_to_cnt <= '0;
        end else if (!w_in_set || w_mode_ev || w_inc_ev || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    assign bus.SetHoursTens    = r_set_ht;
    assign bus.SetHoursUnits   = r_set_hu;
    assign bus.SetMinutesTens  = r_set_mt;
    assign bus.SetMinutesUnits = r_set_mu;
    assign bus.Run             = w_run;
    assign bus.Load            = w_load;
    assign bus.DigitBlank      = w_blank;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl at reduced clock scaling (CLK_HZ=1000, BLINK_HZ=50, TIMEOUT_S=1).
// Stimulus pushes expected output snapshots; a negedge monitor pops and compares them.
module tb_time_set_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    time_set_ctrl_if bus();

    time_set_ctrl #(
        .CLK_HZ    (1000),
        .BLINK_HZ  (50),
        .TIMEOUT_S (1),
        .HOLD_MS   (500),
        .REPEAT_HZ (8)
    ) dut (
        .Clk_100M (clk),
        .Reset    (rst),
        .bus      (bus)
    );

    typedef struct {
        string       name;
        logic [15:0] set;
        logic        run;
        logic        load;
        logic [3:0]  blank;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] load_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_set = 16'h0000;

    wire [15:0] w_set = {bus.SetHoursTens, bus.SetHoursUnits, bus.SetMinutesTens, bus.SetMinutesUnits};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic run, input logic load, input logic [3:0] blank);
        exp_t e;
        e.name  = name;
        e.set   = exp_set;
        e.run   = run;
        e.load  = load;
        e.blank = blank;
        exp_q.push_back(e);
    endtask

    task automatic press(input logic m, input logic i);
        bus.BtnMode = m;
        bus.BtnInc  = i;
        tick();
    endtask

    task automatic release_btns();
        bus.BtnMode = 1'b0;
        bus.BtnInc  = 1'b0;
        tick();
    endtask

    task automatic set_cur(input logic [15:0] v);
        {bus.CurHoursTens, bus.CurHoursUnits, bus.CurMinutesTens, bus.CurMinutesUnits} = v;
    endtask

    // Monitor: compares queued snapshots and checks every Load strobe against the commit queue.
    initial begin
        exp_t        e;
        logic [15:0] ld;
        forever begin
            @(negedge clk);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (w_set !== e.set || bus.Run !== e.run || bus.Load !== e.load || bus.DigitBlank !== e.blank) begin
                    n_fail++;
                    $display("FAIL %s: got set=%h run=%b load=%b blank=%b, expected set=%h run=%b load=%b blank=%b",
                             e.name, w_set, bus.Run, bus.Load, bus.DigitBlank, e.set, e.run, e.load, e.blank);
                end
            end
            if (bus.Load === 1'b1) begin
                n_tests++;
                if (load_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_load: got Load=1 with set=%h, expected Load=0", w_set);
                end else begin
                    ld = load_q.pop_front();
                    if (w_set !== ld) begin
                        n_fail++;
                        $display("FAIL load_value: got set=%h, expected set=%h", w_set, ld);
                    end
                end
            end
        end
    end

    initial begin
        bus.BtnMode = 1'b0;
        bus.BtnInc  = 1'b0;
        set_cur(16'h1234);

        repeat (3) tick();
        expect_out("reset_state", 1'b1, 1'b0, 4'b0000);
        rst = 1'b0;
        tick();
        tick();
        expect_out("idle_after_reset", 1'b1, 1'b0, 4'b0000);

        // Enter set mode and watch the hours pair blink with a 10-cycle half period.
        press(1'b1, 1'b0);
        exp_set = 16'h1234;
        expect_out("enter_set_hours", 1'b0, 1'b0, 4'b0000);
        release_btns();
        repeat (8) tick();
        expect_out("blink_last_visible", 1'b0, 1'b0, 4'b0000);
        tick();
        expect_out("blink_first_blank", 1'b0, 1'b0, 4'b1100);
        repeat (9) tick();
        expect_out("blink_last_blank", 1'b0, 1'b0, 4'b1100);
        tick();
        expect_out("blink_visible_again", 1'b0, 1'b0, 4'b0000);

        // Hours stepping: 12 -> 23 -> 00 -> 09 -> 10.
        for (int k = 0; k < 11; k++) begin
            press(1'b0, 1'b1);
            release_btns();
        end
        exp_set = 16'h2334;
        expect_out("hours_23", 1'b0, 1'b0, 4'b0000);
        press(1'b0, 1'b1);
        exp_set = 16'h0034;
        expect_out("hours_wrap_23_00", 1'b0, 1'b0, 4'b0000);
        release_btns();
        for (int k = 0; k < 9; k++) begin
            press(1'b0, 1'b1);
            release_btns();
        end
        exp_set = 16'h0934;
        expect_out("hours_09", 1'b0, 1'b0, 4'b0000);
        press(1'b0, 1'b1);
        exp_set = 16'h1034;
        expect_out("hours_carry_09_10", 1'b0, 1'b0, 4'b0000);
        release_btns();
        repeat (9) tick();
        expect_out("blink_before_inc", 1'b0, 1'b0, 4'b1100);
        press(1'b0, 1'b1);
        exp_set = 16'h1134;
        expect_out("inc_resets_blink", 1'b0, 1'b0, 4'b0000);
        release_btns();

        // Minutes: 34 -> 59 -> 00 with no hour carry, then commit.
        press(1'b1, 1'b0);
        expect_out("enter_set_minutes", 1'b0, 1'b0, 4'b0000);
        release_btns();
        for (int k = 0; k < 25; k++) begin
            press(1'b0, 1'b1);
            release_btns();
        end
        exp_set = 16'h1159;
        expect_out("minutes_59", 1'b0, 1'b0, 4'b0000);
        press(1'b0, 1'b1);
        exp_set = 16'h1100;
        expect_out("minutes_wrap_hours_kept", 1'b0, 1'b0, 4'b0000);
        release_btns();
        load_q.push_back(16'h1100);
        press(1'b1, 1'b0);
        expect_out("commit_load", 1'b0, 1'b1, 4'b0000);
        release_btns();
        expect_out("run_after_commit", 1'b1, 1'b0, 4'b0000);
        press(1'b0, 1'b1);
        expect_out("inc_ignored_in_run", 1'b1, 1'b0, 4'b0000);
        release_btns();

        // Mode and Inc together: Mode wins, hours untouched, next Inc lands in minutes.
        set_cur(16'h0745);
        press(1'b1, 1'b0);
        exp_set = 16'h0745;
        expect_out("enter_snap_0745", 1'b0, 1'b0, 4'b0000);
        release_btns();
        press(1'b1, 1'b1);
        expect_out("mode_beats_inc", 1'b0, 1'b0, 4'b0000);
        release_btns();
        press(1'b0, 1'b1);
        exp_set = 16'h0746;
        expect_out("inc_lands_in_minutes", 1'b0, 1'b0, 4'b0000);
        release_btns();
        repeat (9) tick();
        expect_out("blink_minutes", 1'b0, 1'b0, 4'b0011);

        // Timeout: 1000 cycles after the last event the edit is abandoned without Load.
        repeat (989) tick();
        expect_out("before_timeout", 1'b0, 1'b0, 4'b0011);
        tick();
        expect_out("timeout_to_run", 1'b1, 1'b0, 4'b0000);

        // Reset in the middle of minute editing.
        set_cur(16'h1234);
        press(1'b1, 1'b0);
        exp_set = 16'h1234;
        release_btns();
        press(1'b1, 1'b0);
        expect_out("in_minutes_before_reset", 1'b0, 1'b0, 4'b0000);
        release_btns();
        rst = 1'b1;
        tick();
        exp_set = 16'h0000;
        expect_out("reset_mid_edit", 1'b1, 1'b0, 4'b0000);
        rst = 1'b0;
        tick();
        tick();

        // Held Inc from 00: one edge, plus repeats at +500/625/750/875 when auto-repeat is built in.
        set_cur(16'h0000);
        press(1'b1, 1'b0);
        expect_out("enter_for_repeat", 1'b0, 1'b0, 4'b0000);
        release_btns();
        bus.BtnInc = 1'b1;
        tick();
        exp_set = 16'h0100;
        expect_out("hold_first_edge", 1'b0, 1'b0, 4'b0000);
        repeat (499) tick();
        expect_out("hold_before_first_repeat", 1'b0, 1'b0, 4'b1100);
        tick();
`ifdef TIME_SET_AUTO_REPEAT_EN
        exp_set = 16'h0200;
`endif
        expect_out("hold_first_repeat_point", 1'b0, 1'b0, 4'b0000);
        repeat (499) tick();
`ifdef TIME_SET_AUTO_REPEAT_EN
        exp_set = 16'h0500;
        expect_out("hold_1000_cycles", 1'b0, 1'b0, 4'b0000);
`else
        expect_out("hold_1000_cycles", 1'b0, 1'b0, 4'b1100);
`endif
        bus.BtnInc = 1'b0;
        tick();
        repeat (199) tick();
`ifdef TIME_SET_AUTO_REPEAT_EN
        expect_out("after_release", 1'b0, 1'b0, 4'b0000);
`else
        expect_out("after_release", 1'b1, 1'b0, 4'b0000);
`endif

        tick();
        tick();
        n_tests++;
        if (load_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_load: got %0d commits outstanding, expected 0", load_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Button-driven controller that sequences manual setting of the HH:MM timekeeper.
- Freezes the timekeeper and snapshots the current time.
- Lets the user step hours, then minutes, while the selected digit pair blinks.
- Commits the edited time with a one-cycle load strobe.
- Sits between the debounced button inputs and the timekeeper/SS_Driver pair. Drives the timekeeper run enable and load bus, and a per-digit blank mask for SS_Driver.

Parameters:
CLK_HZ, 100000000, input clock frequency in Hz.
BLINK_HZ, 2, full blink cycles per second of the edited digit pair.
TIMEOUT_S, 10, seconds without any button press before set mode is abandoned.
HOLD_MS, 500, hold time before auto-repeat starts (AUTO_REPEAT_EN only).
REPEAT_HZ, 8, auto-repeat increment rate (AUTO_REPEAT_EN only).

Ports:
Clk_100M  in  1  system clock; all logic on its rising edge.
Reset  in  1  synchronous, active-high reset.
BtnMode  in  1  debounced mode button level, active-high.
BtnInc  in  1  debounced increment button level, active-high.
CurHoursTens, CurHoursUnits, CurMinutesTens, CurMinutesUnits  in  4 each  live BCD time from the timekeeper.
SetHoursTens, SetHoursUnits, SetMinutesTens, SetMinutesUnits  out  4 each  edited BCD time, registered.
Load  out  1  one-cycle strobe: timekeeper takes Set* and clears seconds and its prescaler.
Run  out  1  high means the timekeeper counts; low means it holds.
DigitBlank  out  4  per-digit blank; bit3=HoursTens ... bit0=MinutesUnits.

Behaviour:
- Reset values:
  - State RUN.
  - Run=1, Load=0, DigitBlank=0000.
  - Set* = 0.
  - Blink, timeout and edge registers cleared.
- Button events: each button is registered once for edge detection. An event is a 0->1 transition, one cycle after the pin rises. A level already high at reset exit gives no event.
- FSM states: RUN, SET_HOURS, SET_MINUTES, COMMIT.
- RUN:
  - Run=1.
  - Inc events are ignored.
  - Mode event: copy Cur* into Set*, go to SET_HOURS, and set Run=0 in the same edge.
- SET_HOURS:
  - Inc event: hours (BCD pair) +1 over the range 00..23, with 23->00.
  - Units 9->0 carries into tens.
  - Mode event: go to SET_MINUTES.
- SET_MINUTES:
  - Inc event: minutes +1 over the range 00..59, with 59->00.
  - There is no carry into hours.
  - Mode event: go to COMMIT.
- COMMIT:
  - Load=1 for exactly this cycle, with Set* stable.
  - Next state RUN, with Run=1 on the following cycle.
- Simultaneous events: Mode and Inc events in the same cycle → Mode wins and the Inc is dropped.
- Blink:
  - The phase toggles every CLK_HZ/(2*BLINK_HZ) cycles.
  - In SET_HOURS, DigitBlank[3:2] = {phase, phase}. In SET_MINUTES, DigitBlank[1:0] = {phase, phase}. Otherwise DigitBlank = 0.
  - The phase and its counter are forced to visible (0) on state entry and on every Inc event.
- Timeout:
  - The counter clears on any event.
  - In SET_HOURS or SET_MINUTES, reaching TIMEOUT_S*CLK_HZ cycles → go to RUN with no Load; Set* is held but ignored.
- Reset mid-edit: returns to RUN with no Load pulse. The timekeeper's own reset governs its time.
- Counter widths are sized with $clog2 of the largest count. There is no overflow at the defaults.

Optional Feature:
Macro: TIME_SET_AUTO_REPEAT_EN.
- Defined:
  - In either set state, BtnInc held high continuously for HOLD_MS after its event generates extra Inc events every CLK_HZ/REPEAT_HZ cycles.
  - Repeat events follow the same rules as normal events (blink reset, timeout clear, Mode priority).
  - Release stops repeating immediately.
- Undefined: only rising edges increment, and the HOLD_MS and REPEAT_HZ parameters are unused.

Decomposition:
- Package clock_pkg holds:
  - the bcd_t typedef (4 bits);
  - the set_state_t enum;
  - the constants HOURS_MAX_TENS=2, HOURS_MAX_UNITS_AT_2=3, MINUTES_MAX_TENS=5, BCD_MAX=9.
- One natural sub-module, bcd_pair_inc: a combinational BCD tens/units +1 with a parametrised wrap value (23 or 59). It is instantiated twice.

Test Plan:
All tests use bench scaling CLK_HZ=1000, BLINK_HZ=50, TIMEOUT_S=1.
1. Cur=12:34, pulse Mode → Run=0 one cycle after the event, Set=12:34, DigitBlank toggles [3:2] every 10 cycles.
2. In SET_HOURS with Set=23, one Inc → Set=00. From 09, one Inc → 10. Inc in RUN → Set unchanged.
3. SET_MINUTES with Set=59, Inc → 00 and hours unchanged. Then Mode → Load high exactly 1 cycle with Set=xx:00, and Run=1 the next cycle.
4. Mode and Inc rising in the same cycle in SET_HOURS → state becomes SET_MINUTES and hours are unchanged.
5. Enter set mode, then no presses for 1000 cycles → state RUN, Load never asserted. Reset asserted mid-SET_MINUTES → RUN, Run=1, DigitBlank=0000.
6. With TIME_SET_AUTO_REPEAT_EN and HOLD_MS=500, REPEAT_HZ=8: hold Inc 1000 cycles in SET_HOURS from 00 → Set=05 (1 edge + 4 repeats at cycles 500, 625, 750, 875).
